// File: rtl/overtemp_alarm_ctrl.sv
// Over-temperature alarm: qualifies a persistent over-temp flag, latches an alarm, blinks LED until acked, counts events.
// Latency: alarm_active rises QUAL_CYCLES+3 clk edges after over_temp_in is first sampled high (2 sync + 1 entry + qualify).
// Backpressure: none; free-running consumer of level inputs, all outputs registered.
module overtemp_alarm_ctrl #(
  parameter int QUAL_CYCLES = 100000,
  parameter int BLINK_HALF  = 25000000,
  parameter int CNT_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             over_temp_in,
  input  logic             ack_btn,
  output logic             alarm_led,
  output logic             alarm_active,
  output logic [CNT_W-1:0] event_count
);

  localparam int QW = (QUAL_CYCLES > 1) ? $clog2(QUAL_CYCLES) : 1;
  localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [QW-1:0] QUAL_LAST  = QW'(QUAL_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUALIFY = 2'd1,
    S_ALARM   = 2'd2,
    S_ACKED   = 2'd3
  } state_t;

  // Synchronizer and edge-detect flops
  logic r_ot_s1, r_ot_s;
  logic r_ack_s1, r_ack_s, r_ack_s_d;
  logic w_ack_rise;

  // State and datapath registers
  state_t           r_state, w_state_nxt;
  logic [QW-1:0]    r_qual_cnt, w_qual_cnt_nxt;
  logic [BW-1:0]    r_blink_cnt, w_blink_cnt_nxt;
  logic [CNT_W-1:0] r_event_count, w_event_count_nxt;
  logic             r_led, w_led_nxt;
  logic             r_active, w_active_nxt;

  // Two-flop synchronizers for both asynchronous inputs, plus a delayed ack copy for rise detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ot_s1   <= 1'b0;
      r_ot_s    <= 1'b0;
      r_ack_s1  <= 1'b0;
      r_ack_s   <= 1'b0;
      r_ack_s_d <= 1'b0;
    end else begin
      r_ot_s1   <= over_temp_in;
      r_ot_s    <= r_ot_s1;
      r_ack_s1  <= ack_btn;
      r_ack_s   <= r_ack_s1;
      r_ack_s_d <= r_ack_s;
    end
  end

  // Bounce is not filtered; only the first rise seen in ALARM matters
  assign w_ack_rise = r_ack_s & ~r_ack_s_d;

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_qual_cnt    <= '0;
      r_blink_cnt   <= '0;
      r_event_count <= '0;
      r_led         <= 1'b0;
      r_active      <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_qual_cnt    <= w_qual_cnt_nxt;
      r_blink_cnt   <= w_blink_cnt_nxt;
      r_event_count <= w_event_count_nxt;
      r_led         <= w_led_nxt;
      r_active      <= w_active_nxt;
    end
  end

  // Next-state, counter and output decode; outputs are computed for the next state so they change on the transition edge
  always_comb begin
    w_state_nxt       = r_state;
    w_qual_cnt_nxt    = r_qual_cnt;
    w_blink_cnt_nxt   = r_blink_cnt;
    w_event_count_nxt = r_event_count;
    w_led_nxt         = r_led;

    case (r_state)
      S_IDLE: begin
        w_led_nxt = 1'b0;
        if (r_ot_s) begin
          w_state_nxt    = S_QUALIFY;
          w_qual_cnt_nxt = '0;
        end
      end

      S_QUALIFY: begin
        w_led_nxt = 1'b0;
        if (!r_ot_s) begin
          // Partial qualification is thrown away
          w_state_nxt = S_IDLE;
        end else if (r_qual_cnt == QUAL_LAST) begin
          w_state_nxt     = S_ALARM;
          w_blink_cnt_nxt = '0;
          w_led_nxt       = 1'b1;
          if (r_event_count != CNT_MAX) begin
            w_event_count_nxt = r_event_count + 1'b1;
          end
        end else begin
          w_qual_cnt_nxt = r_qual_cnt + 1'b1;
        end
      end

      S_ALARM: begin
        // Latched: ot_s falling alone does not leave; the current ot_s decides where an ack goes
        if (w_ack_rise) begin
          if (r_ot_s) begin
            w_state_nxt = S_ACKED;
            w_led_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_led_nxt   = 1'b0;
          end
        end else if (r_blink_cnt == BLINK_LAST) begin
          w_blink_cnt_nxt = '0;
          w_led_nxt       = ~r_led;
        end else begin
          w_blink_cnt_nxt = r_blink_cnt + 1'b1;
        end
      end

      S_ACKED: begin
        w_led_nxt = 1'b1;
        if (!r_ot_s) begin
          w_state_nxt = S_IDLE;
          w_led_nxt   = 1'b0;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_led_nxt   = 1'b0;
      end
    endcase

    w_active_nxt = (w_state_nxt == S_ALARM) || (w_state_nxt == S_ACKED);
  end

  assign alarm_led    = r_led;
  assign alarm_active = r_active;
  assign event_count  = r_event_count;

endmodule

// File: tb/tb_overtemp_alarm_ctrl.sv
// Directed bench for overtemp_alarm_ctrl with QUAL_CYCLES=4, BLINK_HALF=3.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Expected values are hand-derived from the edge-level behaviour of the block.
module tb_overtemp_alarm_ctrl;

  localparam int QC = 4;
  localparam int BH = 3;
  localparam int CW = 4;

  logic          clk;
  logic          rst_n;
  logic          over_temp_in;
  logic          ack_btn;
  logic          alarm_led;
  logic          alarm_active;
  logic [CW-1:0] event_count;

  int n_checks;
  int n_fail;

  overtemp_alarm_ctrl #(
    .QUAL_CYCLES(QC),
    .BLINK_HALF (BH),
    .CNT_W      (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .over_temp_in(over_temp_in),
    .ack_btn     (ack_btn),
    .alarm_led   (alarm_led),
    .alarm_active(alarm_active),
    .event_count (event_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Full alarm from IDLE, then clear it with an ack while the condition is gone
  task automatic alarm_and_clear();
    over_temp_in = 1'b1;
    tick(QC + 3);
    over_temp_in = 1'b0;
    ack_btn      = 1'b1;
    tick(3);
    ack_btn = 1'b0;
    tick(2);
  endtask

  int  blink_exp [6];
  logic seen_high;

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    blink_exp    = '{1, 1, 0, 0, 0, 1};
    rst_n        = 1'b0;
    over_temp_in = 1'b0;
    ack_btn      = 1'b0;
    #1;
    chk("reset_led", 32'(alarm_led), 0);
    chk("reset_active", 32'(alarm_active), 0);
    chk("reset_count", 32'(event_count), 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);

    // Glitch rejection: 3 cycles high never completes a 4-cycle qualification
    over_temp_in = 1'b1;
    tick(3);
    over_temp_in = 1'b0;
    seen_high = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (alarm_active || alarm_led) seen_high = 1'b1;
    end
    chk("glitch_no_alarm", 32'(seen_high), 0);
    chk("glitch_count", 32'(event_count), 0);

    // Qualify: alarm on edge QC+3 after first sampling edge
    over_temp_in = 1'b1;
    tick(QC + 2);
    chk("qual_active_early", 32'(alarm_active), 0);
    tick(1);
    chk("qual_active", 32'(alarm_active), 1);
    chk("qual_led", 32'(alarm_led), 1);
    chk("qual_count", 32'(event_count), 1);

    // Blink and latch with the condition removed
    over_temp_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick(1);
      chk($sformatf("blink_%0d", k + 1), 32'(alarm_led), 32'(blink_exp[k]));
    end
    chk("latched_active", 32'(alarm_active), 1);

    // Ack with condition present -> ACKED steady on
    over_temp_in = 1'b1;
    tick(2);
    ack_btn = 1'b1;
    tick(2);
    chk("ack_pre_state", 32'(alarm_active), 1);
    tick(1);
    chk("acked_led", 32'(alarm_led), 1);
    chk("acked_active", 32'(alarm_active), 1);
    ack_btn = 1'b0;
    tick(3);
    chk("acked_led_steady", 32'(alarm_led), 1);
    ack_btn = 1'b1;
    tick(3);
    chk("acked_ignores_ack", 32'(alarm_led), 1);
    ack_btn = 1'b0;
    over_temp_in = 1'b0;
    tick(2);
    chk("acked_hold_active", 32'(alarm_active), 1);
    tick(1);
    chk("acked_exit_active", 32'(alarm_active), 0);
    chk("acked_exit_led", 32'(alarm_led), 0);
    chk("acked_count", 32'(event_count), 1);

    // Ack with condition gone -> straight back to IDLE
    over_temp_in = 1'b1;
    tick(QC + 3);
    chk("alarm2_active", 32'(alarm_active), 1);
    chk("alarm2_count", 32'(event_count), 2);
    over_temp_in = 1'b0;
    tick(2);
    ack_btn = 1'b1;
    tick(2);
    chk("alarm2_pre_ack", 32'(alarm_active), 1);
    tick(1);
    chk("ack_gone_active", 32'(alarm_active), 0);
    chk("ack_gone_led", 32'(alarm_led), 0);
    ack_btn = 1'b0;
    tick(2);

    // Ack pressed in IDLE is not remembered
    ack_btn = 1'b1;
    tick(3);
    ack_btn = 1'b0;
    tick(3);
    over_temp_in = 1'b1;
    tick(QC + 3);
    chk("alarm3_active", 32'(alarm_active), 1);
    chk("alarm3_led_on", 32'(alarm_led), 1);
    tick(BH);
    chk("alarm3_still_blinking", 32'(alarm_led), 0);
    chk("alarm3_active_hold", 32'(alarm_active), 1);
    chk("alarm3_count", 32'(event_count), 3);
    over_temp_in = 1'b0;
    ack_btn      = 1'b1;
    tick(3);
    ack_btn = 1'b0;
    tick(2);
    chk("alarm3_cleared", 32'(alarm_active), 0);

    // Saturation: 14 more alarms brings the total to 17
    for (int k = 0; k < 12; k++) alarm_and_clear();
    chk("count_at_15", 32'(event_count), 15);
    alarm_and_clear();
    alarm_and_clear();
    chk("count_saturated", 32'(event_count), 15);

    // Asynchronous reset mid-QUALIFY
    over_temp_in = 1'b1;
    tick(4);
    chk("pre_reset_count", 32'(event_count), 15);
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(event_count), 0);
    chk("async_rst_active", 32'(alarm_active), 0);
    chk("async_rst_led", 32'(alarm_led), 0);
    tick(1);
    rst_n = 1'b1;

    // Fresh qualification after reset release
    tick(QC + 2);
    chk("post_rst_active_early", 32'(alarm_active), 0);
    tick(1);
    chk("post_rst_active", 32'(alarm_active), 1);
    chk("post_rst_count", 32'(event_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/overtemp_alarm_ctrl.md
Name: overtemp_alarm_ctrl

Overview:
Downstream stage of the Basys3 temperature indicator. It consumes the single-bit over-temperature flag and qualifies it by requiring persistence. It then latches an alarm, blinks the board LED until the operator acknowledges with a push button, and keeps a saturating count of alarm events for display.

Parameters:
QUAL_CYCLES, 100000, consecutive synchronized cycles of over_temp_in=1 required to raise an alarm (1 ms at 100 MHz); legal range >=1.
BLINK_HALF, 25000000, LED on/off half-period in clk cycles while the alarm is unacknowledged; legal range >=1.
CNT_W, 4, width of event_count.

Ports:
clk  input  1  system clock (100 MHz board clock)
rst_n  input  1  asynchronous, active-low reset
over_temp_in  input  1  raw over-temperature flag from the indicator stage; asynchronous to clk
ack_btn  input  1  raw acknowledge push button, active-high; asynchronous
alarm_led  output  1  board LED: blinking = alarm unacknowledged; steady on = acknowledged but condition still present
alarm_active  output  1  high in ALARM or ACKED
event_count  output  CNT_W  number of qualified alarms since reset; saturating

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, all counters 0, synchronizer flops 0. Reset asserted mid-operation clears everything immediately, including during QUALIFY and ALARM.
- Synchronizers: over_temp_in and ack_btn each pass through 2 flops, giving ot_s and ack_s. ack_rise = ack_s & ~ack_s_d, a one-cycle pulse. Button bounce is not filtered here. Repeated rises are harmless, because only the first rise in ALARM is acted on.
- All outputs are registered, with no combinational path from any input.
- States:
  - IDLE: alarm_led=0. If ot_s=1, go to QUALIFY with qual_cnt=0.
  - QUALIFY: alarm_led=0.
    - If ot_s=0, return to IDLE; partial qualification is discarded.
    - Else if qual_cnt==QUAL_CYCLES-1, go to ALARM, event_count += 1 (saturating), blink_cnt=0, alarm_led=1.
    - Else qual_cnt += 1.
  - ALARM: the alarm is latched, so ot_s falling alone does not leave this state.
    - blink_cnt counts 0..BLINK_HALF-1. On wrap it returns to 0 and toggles alarm_led.
    - On ack_rise: go to ACKED if ot_s=1 in the same cycle, else go to IDLE.
  - ACKED: alarm_led=1 steady. If ot_s=0, go to IDLE. ack_rise is ignored.
- ack_rise in IDLE or QUALIFY is ignored and is not remembered.
- Simultaneous ack_rise and ot_s falling in ALARM: the current ot_s value decides, so the next state is IDLE.
- Latency: from the first clk edge that samples over_temp_in=1 (held high), alarm_active rises on edge QUAL_CYCLES+3.
  - Edges 1-2: synchronizer.
  - Edge 3: enter QUALIFY.
  - Next QUAL_CYCLES edges: qualification.
- Leaving ALARM or ACKED: alarm_led and alarm_active fall on the same edge the state changes.
- event_count:
  - increments exactly once per IDLE -> QUALIFY -> ALARM qualification;
  - holds at 2^CNT_W-1 once reached;
  - is cleared only by reset.
- Re-alarm: after returning to IDLE, a new persistent over_temp_in starts a fresh qualification.

Test Plan:
All scenarios use QUAL_CYCLES=4, BLINK_HALF=3.
1. Qualify and count: hold over_temp_in=1 from edge 0 -> alarm_active=1 and alarm_led=1 at edge 7; event_count=1.
2. Glitch rejection: pulse over_temp_in high for 3 cycles, then low -> state never reaches ALARM; event_count stays 0; alarm_led stays 0.
3. Blink and latch: after alarm, drop over_temp_in -> alarm stays active; alarm_led pattern is 1,1,1,0,0,0,1,... per cycle from ALARM entry.
4. Acknowledge with condition present: press ack_btn while over_temp_in=1 -> 3 edges after press, alarm_led=1 steady (ACKED); release the over-temp condition -> alarm_led=0 and alarm_active=0 3 edges after over_temp_in falls.
5. Acknowledge with condition gone: over_temp_in=0, then press ack_btn in ALARM -> IDLE, outputs 0. Ack pressed in IDLE, then a new alarm -> ack is not remembered and the LED blinks.
6. Saturation and reset: generate 17 alarms -> event_count=15. Assert rst_n=0 mid-QUALIFY -> all outputs 0 immediately, without waiting for a clk edge.
